// File: rtl/seq_mul_reconstruct.sv
// Shift-add reconstructor n = q*d + r; one operation in flight, W RUN cycles after accept, DONE holds result until out_ready.
// Optional macro APPROX_LSB_EN: the low APPROX_BITS of every add step are formed carry-free (XOR), carry into bit APPROX_BITS is dropped.
module seq_mul_reconstruct #(
    parameter int W           = 8,
    parameter int APPROX_BITS = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   q,
    input  logic [W-1:0]   d,
    input  logic [W-1:0]   r,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] n,
    output logic           busy
);

    localparam int NW = 2 * W;
    localparam int CW = $clog2(W) + 1;

`ifdef APPROX_LSB_EN
    localparam bit APPROX_EN = 1'b1;
`else
    localparam bit APPROX_EN = 1'b0;
`endif

    // Bits of the sum that are built from carry-free cells; empty in the exact build.
    localparam logic [NW-1:0] LO_MASK =
        APPROX_EN ? NW'((64'd1 << APPROX_BITS) - 64'd1) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [NW-1:0]   acc;
    logic [W-1:0]    mreg;
    logic [NW-1:0]   dreg;
    logic [CW-1:0]   count;
    logic [NW-1:0]   addend;
    logic [NW-1:0]   sum;
    logic            last_step;

    assign addend    = mreg[0] ? (dreg << count) : '0;
    // Masking both operands keeps carries out of the low field from reaching the upper adder.
    assign sum       = ((acc & ~LO_MASK) + (addend & ~LO_MASK)) | ((acc ^ addend) & LO_MASK);
    assign last_step = (count == CW'(W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last_step) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state == RUN) || (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            mreg  <= '0;
            dreg  <= '0;
            count <= '0;
            n     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mreg  <= q;
                        dreg  <= {{W{1'b0}}, d};
                        acc   <= {{W{1'b0}}, r};
                        count <= '0;
                    end
                end
                RUN: begin
                    acc   <= sum;
                    mreg  <= mreg >> 1;
                    count <= count + CW'(1);
                    // n only changes when a new result completes, so it survives the next RUN.
                    if (last_step) n <= sum;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul_reconstruct.sv
// Bench for seq_mul_reconstruct: directed cases plus random operands against an arithmetic model.
module tb_seq_mul_reconstruct;

    localparam int W  = 8;
    localparam int AB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  q;
    logic [W-1:0]  d;
    logic [W-1:0]  r;
    logic          out_valid;
    logic          out_ready;
    logic [2*W-1:0] n;
    logic          busy;

    int n_checks = 0;
    int n_pass   = 0;

    seq_mul_reconstruct #(.W(W), .APPROX_BITS(AB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q         (q),
        .d         (d),
        .r         (r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .n         (n),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // Reference: plain product in the exact build; with the approximate cells each partial
    // product is added with the low AB bits XORed and only the upper bits summed.
    function automatic logic [15:0] ref_n(input logic [7:0] qq, input logic [7:0] dd,
                                          input logic [7:0] rr);
        int acc;
        int a;
        int mask;
        acc  = int'(rr);
        mask = (1 << AB) - 1;
`ifdef APPROX_LSB_EN
        for (int i = 0; i < W; i++) begin
            if (qq[i]) begin
                a   = int'(dd) << i;
                acc = (((acc >> AB) + (a >> AB)) << AB) | ((acc ^ a) & mask);
            end
        end
`else
        a   = 0;
        acc = int'(qq) * int'(dd) + int'(rr) + (a & mask);
`endif
        return acc[15:0];
    endfunction

    // Called at the negedge following the accept edge; counts edges until out_valid.
    task automatic wait_result(input string tag);
        int lat;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, ":latency"}, lat, W);
    endtask

    task automatic handshake_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ":out_valid_drop"}, out_valid, 0);
        check({tag, ":in_ready_back"}, in_ready, 1);
    endtask

    task automatic run_op(input logic [7:0] qq, input logic [7:0] dd, input logic [7:0] rr,
                          input int hold, input logic [15:0] exp, input string tag);
        @(negedge clk);
        check({tag, ":in_ready"}, in_ready, 1);
        q = qq; d = dd; r = rr; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, ":busy"}, busy, 1);
        wait_result(tag);
        check({tag, ":n"}, n, exp);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, ":hold_valid"}, out_valid, 1);
            check({tag, ":hold_n"}, n, exp);
        end
        handshake_out(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] exp33;
        logic        seen_valid;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; q = '0; d = '0; r = '0;
        #1;
        check("rst:in_ready", in_ready, 1);
        check("rst:out_valid", out_valid, 0);
        check("rst:busy", busy, 0);
        check("rst:n", n, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op(8'h0C, 8'h0A, 8'h07, 0, ref_n(8'h0C, 8'h0A, 8'h07), "basic");
        run_op(8'hFF, 8'hFF, 8'hFF, 1, ref_n(8'hFF, 8'hFF, 8'hFF), "max");
        run_op(8'hA5, 8'h00, 8'h3C, 0, ref_n(8'hA5, 8'h00, 8'h3C), "d_zero");
        run_op(8'h00, 8'h77, 8'h00, 0, ref_n(8'h00, 8'h77, 8'h00), "q_zero");
`ifdef APPROX_LSB_EN
        exp33 = 16'h0005;
`else
        exp33 = 16'h0009;
`endif
        run_op(8'h03, 8'h03, 8'h00, 0, exp33, "q3d3");

        // Backpressure with in_valid held high the whole time.
        @(negedge clk);
        q = 8'h03; d = 8'h05; r = 8'h01; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        q = 8'h02; d = 8'h03; r = 8'h04;
        check("bp:in_ready_run", in_ready, 0);
        wait_result("bp1");
        for (int k = 0; k < 5; k++) begin
            check("bp:n_held", n, ref_n(8'h03, 8'h05, 8'h01));
            check("bp:valid_held", out_valid, 1);
            check("bp:in_ready_done", in_ready, 0);
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp:idle_in_ready", in_ready, 1);
        check("bp:idle_valid", out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp:second_accept", in_ready, 0);
        wait_result("bp2");
        check("bp2:n", n, ref_n(8'h02, 8'h03, 8'h04));
        handshake_out("bp2");

        // Reset three edges into RUN.
        @(negedge clk);
        q = 8'h55; d = 8'h33; r = 8'h09; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst:in_ready", in_ready, 1);
        check("midrst:out_valid", out_valid, 0);
        check("midrst:n", n, 0);
        check("midrst:busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        seen_valid = 1'b0;
        for (int k = 0; k < W + 3; k++) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        check("midrst:no_stale_valid", seen_valid, 0);
        run_op(8'h02, 8'h02, 8'h00, 0, ref_n(8'h02, 8'h02, 8'h00), "post_rst");

        for (int i = 0; i < 20; i++) begin
            logic [7:0] rq;
            logic [7:0] rd;
            logic [7:0] rr;
            rq = 8'($urandom);
            rd = 8'($urandom);
            rr = 8'($urandom);
            run_op(rq, rd, rr, int'($urandom_range(0, 2)), ref_n(rq, rd, rr), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
